// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, hold, squash and a bubble counter.
// Optional write-back forwarding into the latched operands when WB_BYPASS_EN is defined.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regWrite,
    input  logic [4:0]        wb_writeReg,
    input  logic [DATA_W-1:0] wb_writeData,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_stall,
    output logic [15:0]       bubble_cnt
);

    logic              hazard;
    logic [15:0]       bubbleCnt;
    logic [DATA_W-1:0] loadData1;
    logic [DATA_W-1:0] loadData2;

    // A load in EX whose destination feeds either source of the decode slot; r0 is never a dependency.
    always_comb begin
        hazard = in_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 5'd0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    assign id_stall   = hazard | stall;
    assign bubble_cnt = bubbleCnt;

`ifdef WB_BYPASS_EN
    // Covers the register file returning stale data when it is written in the same cycle it is read.
    always_comb begin
        loadData1 = id_rdata1;
        loadData2 = id_rdata2;
        if (wb_regWrite && (wb_writeReg != 5'd0) && (wb_writeReg == id_rs)) begin
            loadData1 = wb_writeData;
        end
        if (wb_regWrite && (wb_writeReg != 5'd0) && (wb_writeReg == id_rt)) begin
            loadData2 = wb_writeData;
        end
    end
`else
    assign loadData1 = id_rdata1;
    assign loadData2 = id_rdata2;

    logic unusedWb;
    assign unusedWb = ^{wb_regWrite, wb_writeReg, wb_writeData};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            bubbleCnt <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
        end else if (stall) begin
            ex_valid  <= ex_valid;
            ex_rs     <= ex_rs;
            ex_rt     <= ex_rt;
            ex_rd     <= ex_rd;
            ex_rdata1 <= ex_rdata1;
            ex_rdata2 <= ex_rdata2;
            ex_imm    <= ex_imm;
            ex_ctrl   <= ex_ctrl;
        end else if (hazard) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            if (bubbleCnt != 16'hFFFF) begin
                bubbleCnt <= bubbleCnt + 16'd1;
            end
        end else begin
            ex_valid  <= in_valid;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= loadData1;
            ex_rdata2 <= loadData2;
            ex_imm    <= id_imm;
            ex_ctrl   <= in_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand sequences for priority,
// async reset mid-hazard, saturation and (macro-dependent) write-back bypass.
module tb_id_ex_stage;

    localparam int KLOAD = 0;
    localparam int KZERO = 1;
    localparam int KHOLD = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [31:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
    logic [7:0]  id_ctrl = '0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_writeReg = '0;
    logic [31:0] wb_writeData = '0;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        id_stall;
    logic [15:0] bubble_cnt;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .in_valid(in_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        fl, st, iv;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [7:0]  ctrl;
        logic        eStall;
        int          kind;
        logic        eValid;
        logic [4:0]  eRt;
        logic [31:0] eD1, eD2;
        logic [7:0]  eCtrl;
        logic [15:0] eCnt;
    } vec_t;

    exp_t sb[$];
    exp_t lastExp;
    int   nCmp = 0;
    int   nBad = 0;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic exp_t mkExp(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                   logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                   logic [7:0] ctrl, logic [15:0] cnt);
        exp_t e;
        e.valid = v; e.rs = rs; e.rt = rt; e.rd = rd;
        e.d1 = d1; e.d2 = d2; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic checkSb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            cmp({nm, ".ex_valid"},   ex_valid,   e.valid);
            cmp({nm, ".ex_rs"},      ex_rs,      e.rs);
            cmp({nm, ".ex_rt"},      ex_rt,      e.rt);
            cmp({nm, ".ex_rd"},      ex_rd,      e.rd);
            cmp({nm, ".ex_rdata1"},  ex_rdata1,  e.d1);
            cmp({nm, ".ex_rdata2"},  ex_rdata2,  e.d2);
            cmp({nm, ".ex_imm"},     ex_imm,     e.imm);
            cmp({nm, ".ex_ctrl"},    ex_ctrl,    e.ctrl);
            cmp({nm, ".bubble_cnt"}, bubble_cnt, e.cnt);
        end
    endtask

    task automatic step(input logic fl, input logic st, input logic iv,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [7:0] ctrl, input logic wbW, input logic [4:0] wbR,
                        input logic [31:0] wbD, input logic expStall, input exp_t e,
                        input string nm);
        @(negedge CLK);
        flush = fl; stall = st; in_valid = iv;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
        wb_regWrite = wbW; wb_writeReg = wbR; wb_writeData = wbD;
        #1 cmp({nm, ".id_stall"}, id_stall, expStall);
        sb.push_back(e);
        @(posedge CLK);
        #1 checkSb(nm);
        lastExp = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        exp_t e;
        logic [15:0] cnt;

        vecs[0]  = '{0,0,1, 12,10,3, 22,5,   32'h11, 8'h04, 0, KLOAD, 1,10,22,5,   8'h04, 16'd0};
        vecs[1]  = '{0,0,1, 1,8,8,   100,200,32'h12, 8'h01, 0, KLOAD, 1,8,100,200, 8'h01, 16'd0};
        vecs[2]  = '{0,0,1, 8,2,6,   11,12,  32'h13, 8'h04, 1, KZERO, 0,0,0,0,     8'h00, 16'd1};
        vecs[3]  = '{0,0,1, 8,2,6,   11,12,  32'h13, 8'h04, 0, KLOAD, 1,2,11,12,   8'h04, 16'd1};
        vecs[4]  = '{0,0,1, 3,0,4,   5,6,    32'h14, 8'h01, 0, KLOAD, 1,0,5,6,     8'h01, 16'd1};
        vecs[5]  = '{0,0,1, 0,0,5,   7,8,    32'h15, 8'h04, 0, KLOAD, 1,0,7,8,     8'h04, 16'd1};
        vecs[6]  = '{0,0,0, 9,9,9,   1,2,    32'h16, 8'hFF, 0, KLOAD, 0,9,1,2,     8'h00, 16'd1};
        vecs[7]  = '{0,0,1, 4,5,6,   30,31,  32'h17, 8'h03, 0, KLOAD, 1,5,30,31,   8'h03, 16'd1};
        vecs[8]  = '{0,0,0, 5,6,7,   40,41,  32'h18, 8'h04, 0, KLOAD, 0,6,40,41,   8'h00, 16'd1};
        vecs[9]  = '{0,0,1, 1,7,3,   50,51,  32'h19, 8'h01, 0, KLOAD, 1,7,50,51,   8'h01, 16'd1};
        vecs[10] = '{0,1,1, 2,7,8,   60,61,  32'h1A, 8'h04, 1, KHOLD, 1,7,50,51,   8'h01, 16'd1};
        vecs[11] = '{0,0,1, 2,7,8,   60,61,  32'h1A, 8'h04, 1, KZERO, 0,0,0,0,     8'h00, 16'd2};
        vecs[12] = '{0,0,1, 2,7,8,   60,61,  32'h1A, 8'h04, 0, KLOAD, 1,7,60,61,   8'h04, 16'd2};
        vecs[13] = '{1,0,1, 3,7,9,   70,71,  32'h1B, 8'h01, 0, KZERO, 0,0,0,0,     8'h00, 16'd2};

        // Reset held for two edges with live inputs present.
        RST = 1'b1;
        in_valid = 1'b1; id_rs = 12; id_rt = 10; id_rd = 3;
        id_rdata1 = 22; id_rdata2 = 5; id_imm = 32'h11; id_ctrl = 8'h04;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mkExp(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0));
            @(posedge CLK);
            #1 checkSb("reset");
        end
        @(negedge CLK);
        RST = 1'b0;
        lastExp = mkExp(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0);

        for (int i = 0; i < 14; i++) begin
            case (vecs[i].kind)
                KLOAD:   e = mkExp(vecs[i].eValid, vecs[i].rs, vecs[i].eRt, vecs[i].rd,
                               vecs[i].eD1, vecs[i].eD2, vecs[i].imm, vecs[i].eCtrl, vecs[i].eCnt);
                KZERO:   e = mkExp(vecs[i].eValid, 0, vecs[i].eRt, 0,
                               vecs[i].eD1, vecs[i].eD2, 0, vecs[i].eCtrl, vecs[i].eCnt);
                default: e = mkExp(vecs[i].eValid, lastExp.rs, vecs[i].eRt, lastExp.rd,
                               vecs[i].eD1, vecs[i].eD2, lastExp.imm, vecs[i].eCtrl, vecs[i].eCnt);
            endcase
            step(vecs[i].fl, vecs[i].st, vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                 vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].ctrl, 0, 0, 0,
                 vecs[i].eStall, e, $sformatf("vec%0d", i));
        end

        // Flush + stall + pending hazard: flush wins, no bubble counted; then 3-cycle hold.
        step(0,0,1, 1,8,8, 100,200, 5, 8'h01, 0,0,0, 0, mkExp(1,1,8,8,100,200,5,8'h01,16'd2), "prioLoad");
        step(1,1,1, 8,3,4, 9,9, 6, 8'h04, 0,0,0, 1, mkExp(0,0,0,0,0,0,0,8'h00,16'd2), "prioFlush");
        step(0,0,1, 6,7,9, 32'hAA,32'hBB, 32'hCC, 8'h10, 0,0,0, 0,
             mkExp(1,6,7,9,32'hAA,32'hBB,32'hCC,8'h10,16'd2), "prioLoad2");
        for (int i = 0; i < 3; i++) begin
            step(0,1,1, 8,8,1, 1,2, 3, 8'h01, 0,0,0, 1, lastExp, $sformatf("hold%0d", i));
        end

        // Asynchronous reset while a hazard is pending.
        step(0,0,1, 1,8,8, 100,200, 5, 8'h01, 0,0,0, 0, mkExp(1,1,8,8,100,200,5,8'h01,16'd2), "rstLoad");
        @(negedge CLK);
        in_valid = 1; id_rs = 8; id_rt = 3; id_rd = 4; id_rdata1 = 9; id_rdata2 = 9;
        id_imm = 6; id_ctrl = 8'h04;
        #1 cmp("rstHz.id_stall", id_stall, 1'b1);
        #1 RST = 1'b1;
        #1;
        cmp("rstAsync.ex_valid", ex_valid, 1'b0);
        cmp("rstAsync.ex_ctrl", ex_ctrl, 8'h00);
        cmp("rstAsync.ex_rt", ex_rt, 5'd0);
        cmp("rstAsync.ex_rdata1", ex_rdata1, 32'd0);
        cmp("rstAsync.bubble_cnt", bubble_cnt, 16'd0);
        cmp("rstAsync.id_stall", id_stall, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        step(0,0,1, 8,3,4, 9,9, 6, 8'h04, 0,0,0, 0, mkExp(1,8,3,4,9,9,6,8'h04,16'd0), "rstFirst");

        // Write-back bypass (only effective with WB_BYPASS_EN).
        step(0,0,1, 1,4,2, 3,0, 7, 8'h04, 1,4,99, 0,
             mkExp(1,1,4,2,3, BYP ? 32'd99 : 32'd0, 7,8'h04,16'd0), "bypRt");
        step(0,0,1, 4,5,2, 3,7, 7, 8'h04, 1,4,99, 0,
             mkExp(1,4,5,2, BYP ? 32'd99 : 32'd3, 7, 7,8'h04,16'd0), "bypRs");
        step(0,0,1, 0,0,2, 1,2, 7, 8'h04, 1,0,99, 0, mkExp(1,0,0,2,1,2,7,8'h04,16'd0), "bypR0");
        step(0,0,1, 4,4,2, 1,2, 7, 8'h04, 0,4,99, 0, mkExp(1,4,4,2,1,2,7,8'h04,16'd0), "bypNoWr");

        // Saturation: preload the counter just below the ceiling, then keep inserting bubbles.
        @(negedge CLK);
        force dut.bubbleCnt = 16'hFFFD;
        #1 release dut.bubbleCnt;
        cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            step(0,0,1, 1,8,8, 100,200, 5, 8'h01, 0,0,0, 0,
                 mkExp(1,1,8,8,100,200,5,8'h01,cnt), $sformatf("satLoad%0d", k));
            cnt = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;
            step(0,0,1, 8,2,6, 11,12, 6, 8'h04, 0,0,0, 1,
                 mkExp(0,0,0,0,0,0,0,8'h00,cnt), $sformatf("satBub%0d", k));
        end
        cmp("satFinal.bubble_cnt", bubble_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Captures the two register read operands, the register specifiers, the immediate and the control word each cycle, and presents them to the EX stage.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Supports an external stall (hold) and a flush (squash), and counts inserted bubbles.

Parameters:
- DATA_W, 32, width of register operands and write-back data.
- CTRL_W, 8, width of the opaque control word passed from decode to EX.
- MEMREAD_BIT, 0, bit index within the control word that marks a load instruction.

Ports:
- CLK  input  1  rising-edge clock, shared with the register file.
- RST  input  1  asynchronous active-high reset.
- stall  input  1  hold request from downstream (multi-cycle EX).
- flush  input  1  squash request (branch or jump taken).
- in_valid  input  1  decode slot holds a real instruction.
- id_rs  input  5  source register 1 specifier (drives readReg1).
- id_rt  input  5  source register 2 specifier (drives readReg2).
- id_rd  input  5  destination specifier.
- id_rdata1  input  DATA_W  register file readData1.
- id_rdata2  input  DATA_W  register file readData2.
- id_imm  input  32  sign-extended immediate.
- id_ctrl  input  CTRL_W  decoded control word.
- wb_regWrite  input  1  write-back write enable (same signal as the register file regWrite).
- wb_writeReg  input  5  write-back destination register.
- wb_writeData  input  DATA_W  write-back data.
- ex_valid  output  1  EX slot holds a real instruction.
- ex_rs, ex_rt, ex_rd  output  5 each  latched register specifiers.
- ex_rdata1, ex_rdata2  output  DATA_W  latched operands.
- ex_imm  output  32  latched immediate.
- ex_ctrl  output  CTRL_W  latched control word; all zero when the slot is a bubble.
- id_stall  output  1  combinational; decode and PC must hold while high.
- bubble_cnt  output  16  saturating count of load-use bubbles.

Behaviour:
- Reset: the design uses one clock, CLK. RST is asynchronous and active-high. While RST is high, every registered output is 0, including ex_valid, ex_ctrl, all ex_* data and specifiers, and bubble_cnt.
- Hazard term (combinational):
  - hz = in_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Register 0 never causes a hazard.
- id_stall = hz | stall. The output is combinational, with no latency.
- Update on each CLK rising edge, in strict priority order:
  1. flush: ex_valid <= 0 and ex_ctrl <= 0. All other ex_* registers are cleared to 0. bubble_cnt is unchanged.
  2. stall: all ex_* registers hold their current values; bubble_cnt is unchanged.
  3. hz: insert a bubble (ex_valid <= 0, ex_ctrl <= 0, other ex_* cleared). bubble_cnt increments, saturating at 16'hFFFF.
  4. Otherwise: load every id_* input into the matching ex_* register, and set ex_valid <= in_valid. If in_valid = 0, ex_ctrl is forced to 0.
- Flush and stall asserted together: flush wins.
- Stall and hz asserted together: hold, with no bubble counted. hz is re-evaluated once stall drops.
- Hazard resolution takes exactly one bubble cycle. After the bubble, ex_valid = 0, so hz drops and the dependent instruction loads on the next edge.
- Latency: one cycle from id_* to ex_*.
- RST asserted mid-stall or mid-hazard clears all registered state immediately. The first edge after RST deasserts behaves as a normal load.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - On a normal load, if wb_regWrite & (wb_writeReg != 0) & (wb_writeReg == id_rs), ex_rdata1 latches wb_writeData instead of id_rdata1.
  - The same rule applies independently to id_rt and ex_rdata2.
  - This covers the register file's write-then-read-same-cycle case.
- Undefined: the wb_* ports exist but are ignored; operands always come from id_rdata1/id_rdata2.

Test Plan:
- Reset then load: hold RST for 2 cycles, then apply in_valid=1, id_rs=12, id_rt=10, id_rd=3, id_rdata1=22, id_rdata2=5, id_ctrl=8'h04. After 1 edge: ex_valid=1, ex_rdata1=22, ex_rdata2=5, ex_ctrl=8'h04; all outputs were 0 during reset.
- Load-use: EX holds a load (ex_ctrl[0]=1, ex_rt=8) and decode presents id_rs=8. Required: id_stall=1 immediately; next edge gives ex_valid=0, ex_ctrl=0, bubble_cnt=1; the edge after that loads the dependent instruction.
- Register 0: EX holds a load with ex_rt=0 and decode presents id_rs=0. Required: id_stall=0 and no bubble inserted.
- Priority: flush=1 and stall=1 together with a pending hazard. Required: ex_valid=0 and bubble_cnt unchanged. Then stall=1 alone for 3 cycles: all ex_* outputs unchanged.
- Saturation: force 65 537 consecutive hazard bubbles. Required: bubble_cnt=16'hFFFF and it holds there.
- Bypass (WB_BYPASS_EN defined): wb_regWrite=1, wb_writeReg=4, wb_writeData=99, id_rt=4, id_rdata2=0. Required after the edge: ex_rdata2=99. With the macro undefined: ex_rdata2=0.
